// File: rtl/int_sequencer_pkg.sv
// Shared definitions for the interrupt entry/return sequencer: state encoding,
// default vector layout and the id-to-onehot helper.
package int_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ENTRY  = 3'd1,
    ST_VECTOR = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_RET    = 3'd4,
    ST_RESUME = 3'd5
  } seq_state_e;

  localparam int unsigned ID_W = 3;

  localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0400;
  localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0010;

  localparam logic [ID_W-1:0] ONEHOT_NONE = 3'b000;
  localparam logic [ID_W-1:0] ONEHOT_ID1  = 3'b001;
  localparam logic [ID_W-1:0] ONEHOT_ID2  = 3'b010;
  localparam logic [ID_W-1:0] ONEHOT_ID3  = 3'b100;

  // Id 0 means "no interrupt" and maps to an empty mask.
  function automatic logic [ID_W-1:0] id_onehot(input logic [ID_W-1:0] id);
    logic [ID_W-1:0] mask;
    case (id)
      3'd1:    mask = ONEHOT_ID1;
      3'd2:    mask = ONEHOT_ID2;
      3'd3:    mask = ONEHOT_ID3;
      default: mask = ONEHOT_NONE;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/int_sequencer_prio_enc.sv
// Priority encoder: one-hot of the highest set bit of the input vector
// (all zeros when the input is zero).
module int_prio_enc #(
  parameter int unsigned W = 3
) (
  input  logic [W-1:0] vec_i,
  output logic [W-1:0] onehot_o
);

  // A bit survives only if no higher-numbered bit is set.
  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    if (gi == W - 1) begin : g_top
      assign onehot_o[gi] = vec_i[gi];
    end else begin : g_lower
      assign onehot_o[gi] = vec_i[gi] & ~(|vec_i[W-1:gi+1]);
    end
  end

endmodule

// File: rtl/int_sequencer.sv
// Interrupt entry/return sequencer: saves EPC, marks the id in service, masks
// interrupts, redirects fetch to the handler, and unwinds on eret.
// Optional nesting while a handler runs is enabled by defining INT_NEST_EN.
module int_sequencer
  import int_sequencer_pkg::*;
#(
  parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
  parameter logic [31:0] VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        int_req,
  input  logic [2:0]  int_id,
  input  logic [31:0] pc,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic        epc_w_en,
  output logic [31:0] epc_w_data,
  output logic        irs_set_en,
  output logic        irs_clr_en,
  output logic [2:0]  irs_w_mask,
  output logic        ie_w_en,
  output logic        ie_w_data,
  output logic        pc_redir,
  output logic [31:0] pc_redir_addr,
  output logic        busy
);

  seq_state_e      state_q;
  logic [ID_W-1:0] isr_q;
  logic [ID_W-1:0] id_q;

  logic [ID_W-1:0] ret_onehot;
  logic [ID_W-1:0] isr_ret_d;
  logic [31:0]     vec_addr;
  logic            take_int;
  logic            in_entry;
  logic            in_vector;
  logic            in_ret;
  logic            in_resume;

  int_prio_enc #(
    .W (ID_W)
  ) u_prio_enc (
    .vec_i    (isr_q),
    .onehot_o (ret_onehot)
  );

  assign take_int  = int_req && (int_id != 3'd0);
  assign isr_ret_d = isr_q & ~ret_onehot;

  // Handler vectors start at id 1; arithmetic wraps at 32 bits.
  assign vec_addr  = VEC_BASE + (({29'd0, id_q}) - 32'd1) * VEC_STRIDE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      isr_q   <= ONEHOT_NONE;
      id_q    <= 3'd0;
    end else if (en) begin
      case (state_q)
        ST_IDLE: begin
          if (take_int) begin
            id_q    <= int_id;
            state_q <= ST_ENTRY;
          end
        end
        ST_ENTRY: begin
          isr_q   <= isr_q | id_onehot(id_q);
          state_q <= ST_VECTOR;
        end
        ST_VECTOR: begin
          state_q <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (eret) begin
            state_q <= ST_RET;
`ifdef INT_NEST_EN
          end else if (take_int) begin
            // The coprocessor only raises ids that outrank the running handler.
            id_q    <= int_id;
            state_q <= ST_ENTRY;
`endif
          end
        end
        ST_RET: begin
          isr_q   <= isr_ret_d;
          state_q <= ST_RESUME;
        end
        ST_RESUME: begin
          state_q <= (isr_q == ONEHOT_NONE) ? ST_IDLE : ST_ACTIVE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Strobes are qualified by en so a stalled pipeline never sees a write twice.
  assign in_entry  = en && (state_q == ST_ENTRY);
  assign in_vector = en && (state_q == ST_VECTOR);
  assign in_ret    = en && (state_q == ST_RET);
  assign in_resume = en && (state_q == ST_RESUME);

  assign epc_w_en   = in_entry;
  assign epc_w_data = in_entry ? pc : 32'd0;

  assign irs_set_en = in_entry;
  assign irs_clr_en = in_ret;

  always_comb begin
    irs_w_mask = ONEHOT_NONE;
    if (in_entry) begin
      irs_w_mask = id_onehot(id_q);
    end else if (in_ret) begin
      irs_w_mask = ~ret_onehot;
    end
  end

  assign ie_w_en   = in_entry || in_ret;
  assign ie_w_data = in_ret;

  assign pc_redir = in_vector || in_resume;

  always_comb begin
    pc_redir_addr = 32'd0;
    if (in_vector) begin
      pc_redir_addr = vec_addr;
    end else if (in_resume) begin
      pc_redir_addr = epc;
    end
  end

  assign busy = (state_q == ST_ENTRY) || (state_q == ST_VECTOR) ||
                (state_q == ST_RET)   || (state_q == ST_RESUME);

endmodule

// File: tb/tb_int_sequencer.sv
// Directed bench for int_sequencer; the nested-entry steps follow INT_NEST_EN.
module tb_int_sequencer;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        int_req;
  logic [2:0]  int_id;
  logic [31:0] pc;
  logic        eret;
  logic [31:0] epc;
  logic        epc_w_en;
  logic [31:0] epc_w_data;
  logic        irs_set_en;
  logic        irs_clr_en;
  logic [2:0]  irs_w_mask;
  logic        ie_w_en;
  logic        ie_w_data;
  logic        pc_redir;
  logic [31:0] pc_redir_addr;
  logic        busy;

  int vectors;
  int miscompares;

  int_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .int_req       (int_req),
    .int_id        (int_id),
    .pc            (pc),
    .eret          (eret),
    .epc           (epc),
    .epc_w_en      (epc_w_en),
    .epc_w_data    (epc_w_data),
    .irs_set_en    (irs_set_en),
    .irs_clr_en    (irs_clr_en),
    .irs_w_mask    (irs_w_mask),
    .ie_w_en       (ie_w_en),
    .ie_w_data     (ie_w_data),
    .pc_redir      (pc_redir),
    .pc_redir_addr (pc_redir_addr),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: {epc_w_en, epc_w_data, set, clr, mask, ie_w_en, ie_w_data, redir, addr, busy}
  function automatic logic [73:0] pack(input logic ew, input logic [31:0] ed,
                                       input logic se, input logic ce,
                                       input logic [2:0] m, input logic iw,
                                       input logic id, input logic rd,
                                       input logic [31:0] ra, input logic b);
    return {ew, ed, se, ce, m, iw, id, rd, ra, b};
  endfunction

  function automatic logic [73:0] e_quiet(input logic b);
    return pack(1'b0, 32'd0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'd0, b);
  endfunction

  function automatic logic [73:0] e_entry(input logic [31:0] p, input logic [2:0] m);
    return pack(1'b1, p, 1'b1, 1'b0, m, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
  endfunction

  function automatic logic [73:0] e_vec(input logic [31:0] a);
    return pack(1'b0, 32'd0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, a, 1'b1);
  endfunction

  function automatic logic [73:0] e_ret(input logic [2:0] m);
    return pack(1'b0, 32'd0, 1'b0, 1'b1, m, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
  endfunction

  function automatic logic [73:0] e_res(input logic [31:0] a);
    return pack(1'b0, 32'd0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, a, 1'b1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [73:0] expected);
    logic [73:0] observed;
    #1;
    observed = {epc_w_en, epc_w_data, irs_set_en, irs_clr_en, irs_w_mask,
                ie_w_en, ie_w_data, pc_redir, pc_redir_addr, busy};
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0; en = 1'b0; int_req = 1'b0; int_id = 3'd0;
    pc = 32'd0; eret = 1'b0; epc = 32'd0;
    tick(); tick();
    check("reset", e_quiet(1'b0));
    rst_n = 1'b1;

    // Request while en=0 must not start a sequence
    int_req = 1'b1; int_id = 3'd1;
    tick();
    check("idle_en0", e_quiet(1'b0));
    int_req = 1'b0; en = 1'b1;

    // id=2 entry at pc 0x100, return via eret
    int_req = 1'b1; int_id = 3'd2; pc = 32'h100;
    check("idle_req", e_quiet(1'b0));
    tick();
    int_req = 1'b0;
    check("entry_id2", e_entry(32'h100, 3'b010));
    tick();
    check("vector_id2", e_vec(32'h410));
    tick();
    eret = 1'b1; epc = 32'h100;
    check("active_id2", e_quiet(1'b0));
    tick();
    eret = 1'b0;
    check("ret_id2", e_ret(3'b101));
    tick();
    check("resume_id2", e_res(32'h100));
    tick();
    eret = 1'b1;
    check("idle_after_ret", e_quiet(1'b0));
    tick();
    eret = 1'b0;
    check("idle_eret_ignored", e_quiet(1'b0));

    // Stall three cycles in ENTRY
    int_req = 1'b1; int_id = 3'd1; pc = 32'h200;
    tick();
    int_req = 1'b0; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("entry_stall%0d", i), e_quiet(1'b1));
      tick();
    end
    en = 1'b1;
    check("entry_release", e_entry(32'h200, 3'b001));
    tick();
    check("vector_id1", e_vec(32'h400));
    tick();

    // eret and int_req together in ACTIVE: return wins
    eret = 1'b1; int_req = 1'b1; int_id = 3'd3; epc = 32'h200; pc = 32'h300;
    check("active_collide", e_quiet(1'b0));
    tick();
    eret = 1'b0;
    check("ret_collide", e_ret(3'b110));
    tick();
    check("resume_collide", e_res(32'h200));
    tick();
    check("idle_reeval", e_quiet(1'b0));
    tick();
    int_req = 1'b0;
    check("entry_id3", e_entry(32'h300, 3'b100));
    tick();
    check("vector_id3", e_vec(32'h420));
    tick();
    eret = 1'b1; epc = 32'h300;
    tick();
    eret = 1'b0;
    check("ret_id3", e_ret(3'b011));
    tick();
    check("resume_id3", e_res(32'h300));
    tick();

    // Outer handler id=1, then id=3 requested while it runs
    int_req = 1'b1; int_id = 3'd1; pc = 32'h500;
    tick();
    int_req = 1'b0;
    check("entry_outer", e_entry(32'h500, 3'b001));
    tick();
    check("vector_outer", e_vec(32'h400));
    tick();
    int_req = 1'b1; int_id = 3'd3; pc = 32'h600;
    tick();
`ifdef INT_NEST_EN
    int_req = 1'b0;
    check("entry_nested", e_entry(32'h600, 3'b100));
    tick();
    check("vector_nested", e_vec(32'h420));
    tick();
    eret = 1'b1; epc = 32'h600;
    check("active_nested", e_quiet(1'b0));
    tick();
    eret = 1'b0;
    check("ret_nested", e_ret(3'b011));
    tick();
    check("resume_nested", e_res(32'h600));
    tick();
    eret = 1'b1; epc = 32'h500;
    check("active_outer", e_quiet(1'b0));
    tick();
`else
    check("nest_ignored0", e_quiet(1'b0));
    tick();
    check("nest_ignored1", e_quiet(1'b0));
    int_req = 1'b0; eret = 1'b1; epc = 32'h500;
    tick();
`endif
    eret = 1'b0;
    check("ret_outer", e_ret(3'b110));
    tick();
    check("resume_outer", e_res(32'h500));
    tick();
    check("idle_outer", e_quiet(1'b0));

    // Reset during VECTOR discards the sequence and the in-service mirror
    int_req = 1'b1; int_id = 3'd2; pc = 32'h700;
    tick();
    int_req = 1'b0;
    check("entry_pre_rst", e_entry(32'h700, 3'b010));
    tick();
    check("vector_pre_rst", e_vec(32'h410));
    rst_n = 1'b0;
    tick();
    check("reset_in_vector", e_quiet(1'b0));
    rst_n = 1'b1;
    tick();
    check("idle_post_rst", e_quiet(1'b0));
    int_req = 1'b1; int_id = 3'd1; pc = 32'h800;
    tick();
    int_req = 1'b0;
    check("entry_post_rst", e_entry(32'h800, 3'b001));
    tick();
    check("vector_post_rst", e_vec(32'h400));
    tick();
    eret = 1'b1; epc = 32'h800;
    tick();
    eret = 1'b0;
    check("ret_post_rst", e_ret(3'b110));
    tick();
    check("resume_post_rst", e_res(32'h800));
    tick();
    check("idle_final", e_quiet(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
